porta_logica_acc: RTL and testbench

- Parametrised, registered successor to the team's single-bit combinational gates.
- WIDTH-bit bitwise logic unit with eight selectable operations and valid/ready handshakes on both input and output.
- Accumulate mode folds a burst of words into one result. Used as the lab's first sequential datapath block, between stimulus registers and a result display/checker.

---
 rtl/porta_logica_acc.sv | 129 ++++++++++++
 tb/tb_porta_logica_acc.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/porta_logica_acc.sv
// Registered WIDTH-bit bitwise logic unit with valid/ready handshakes and burst accumulation.
// Optional zero flag output zf is enabled by defining PORTA_LOGICA_ZERO_FLAG_EN.
module porta_logica_bit (
  input  logic [2:0] op,
  input  logic       x,
  input  logic       z,
  output logic       f
);
  always_comb begin
    f = 1'b0;
    case (op)
      3'b000: f = x & z;
      3'b001: f = x | z;
      3'b010: f = x ^ z;
      3'b011: f = ~(x & z);
      3'b100: f = ~(x | z);
      3'b101: f = ~(x ^ z);
      3'b110: f = ~x;
      3'b111: f = x;
      default: f = 1'b0;
    endcase
  end
endmodule

module porta_logica_acc #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             acc_mode,
  input  logic             last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [CNT_W-1:0] count
`ifdef PORTA_LOGICA_ZERO_FLAG_EN
  , output logic           zf
`endif
);
  typedef enum logic {IDLE, ACCUM} state_t;

  typedef struct packed {
    logic [2:0]       op;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] z;
  } lane_req_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] acc, acc_d, y_d, f;
  logic [CNT_W-1:0] count_d, count_inc;
  logic [2:0]       op_q, op_d;
  logic             out_valid_d, accept;
  lane_req_t        req;

  // One lane array serves both modes: in ACCUM the accumulator takes the x slot and a takes z.
  assign req = (state == ACCUM) ? '{op: op_q, x: acc, z: a} : '{op: op, x: a, z: b};

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    porta_logica_bit u_bit (.op(req.op), .x(req.x[i]), .z(req.z[i]), .f(f[i]));
  end

  assign in_ready  = (state == ACCUM) ? 1'b1 : (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign count_inc = (count == '1) ? count : count + 1'b1;

  always_comb begin
    state_d     = state;
    acc_d       = acc;
    y_d         = y;
    count_d     = count;
    op_d        = op_q;
    out_valid_d = out_valid;
    if (out_valid && out_ready) out_valid_d = 1'b0;
    if (accept) begin
      if (state == IDLE) begin
        count_d = {{(CNT_W-1){1'b0}}, 1'b1};
        if (acc_mode && !last) begin
          acc_d   = f;
          op_d    = op;
          state_d = ACCUM;
        end else begin
          y_d         = f;
          out_valid_d = 1'b1;
        end
      end else begin
        acc_d   = f;
        count_d = count_inc;
        if (last) begin
          y_d         = f;
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      y         <= '0;
      count     <= '0;
      op_q      <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_d;
      acc       <= acc_d;
      y         <= y_d;
      count     <= count_d;
      op_q      <= op_d;
      out_valid <= out_valid_d;
    end
  end

`ifdef PORTA_LOGICA_ZERO_FLAG_EN
  // Flag tracks y exactly: only refreshed on the edges that load a new y.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        zf <= 1'b0;
    else if (out_valid_d && y_d != y)  zf <= (y_d == '0);
    else if (accept && out_valid_d)    zf <= (y_d == '0);
  end
`endif
endmodule

// File: tb/tb_porta_logica_acc.sv
// Directed self-checking bench for porta_logica_acc (WIDTH=8, CNT_W=4).
module tb_porta_logica_acc;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, acc_mode, last, out_valid, out_ready;
  logic [7:0] a, b, y;
  logic [2:0] op;
  logic [3:0] count;
`ifdef PORTA_LOGICA_ZERO_FLAG_EN
  logic       zf;
`endif
  int checks   = 0;
  int failures = 0;

  porta_logica_acc #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .acc_mode(acc_mode), .last(last),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .count(count)
`ifdef PORTA_LOGICA_ZERO_FLAG_EN
    , .zf(zf)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] sweep [8];
    sweep = '{8'h30, 8'hFC, 8'hCC, 8'hCF, 8'h03, 8'h33, 8'h0F, 8'hF0};

    rst_n = 1'b0; in_valid = 1'b0; acc_mode = 1'b0; last = 1'b0;
    out_ready = 1'b0; a = '0; b = '0; op = '0;
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y", y, 8'h00);
    chk("rst_count", count, 0);
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", in_ready, 1);

    // op sweep, one result per cycle
    out_ready = 1'b1; in_valid = 1'b1; a = 8'hF0; b = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      op = 3'(i);
      tick();
      chk($sformatf("sweep_y_op%0d", i), y, sweep[i]);
      chk($sformatf("sweep_vld_op%0d", i), out_valid, 1);
      chk($sformatf("sweep_cnt_op%0d", i), count, 1);
    end
    in_valid = 1'b0;
    tick();
    chk("sweep_drain_vld", out_valid, 0);
    chk("sweep_count_hold", count, 1);

    // backpressure
    out_ready = 1'b0; in_valid = 1'b1; op = 3'b000; a = 8'hFF; b = 8'h0F;
    tick();
    chk("bp_y", y, 8'h0F);
    a = 8'hAA; b = 8'h55; op = 3'b001;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("bp_hold_y_%0d", i), y, 8'h0F);
      chk($sformatf("bp_hold_vld_%0d", i), out_valid, 1);
      chk($sformatf("bp_hold_rdy_%0d", i), in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_release_y", y, 8'hFF);
    chk("bp_release_vld", out_valid, 1);
    in_valid = 1'b0;
    tick();
    chk("bp_drain_vld", out_valid, 0);

    // AND burst, op change mid-burst ignored
    in_valid = 1'b1; acc_mode = 1'b1; last = 1'b0; op = 3'b000; a = 8'hFF; b = 8'hF7;
    tick();
    chk("and_b1_vld", out_valid, 0);
    chk("and_b1_cnt", count, 1);
    a = 8'h7F; b = 8'h00; op = 3'b001;
    tick();
    chk("and_b2_vld", out_valid, 0);
    chk("and_b2_cnt", count, 2);
    a = 8'hFE; last = 1'b1;
    tick();
    chk("and_y", y, 8'h76);
    chk("and_vld", out_valid, 1);
    chk("and_cnt", count, 3);
    in_valid = 1'b0; last = 1'b0; acc_mode = 1'b0;
    tick();
    chk("and_drain_vld", out_valid, 0);
    chk("and_count_hold", count, 3);

    // single-beat burst
    in_valid = 1'b1; acc_mode = 1'b1; last = 1'b1; op = 3'b101; a = 8'h0F; b = 8'h0F;
    tick();
    chk("single_burst_y", y, 8'hFF);
    chk("single_burst_vld", out_valid, 1);
    chk("single_burst_cnt", count, 1);
    in_valid = 1'b0; last = 1'b0;
    tick();

    // XOR burst of 17 beats, count saturates at 15
    in_valid = 1'b1; acc_mode = 1'b1; op = 3'b010; a = 8'h01; b = 8'h00;
    for (int i = 0; i < 17; i++) begin
      last = (i == 16);
      tick();
      if (i < 16) chk($sformatf("xor_mid_vld_%0d", i), out_valid, 0);
    end
    chk("xor_y", y, 8'h01);
    chk("xor_cnt_sat", count, 4'hF);
    chk("xor_vld", out_valid, 1);
    in_valid = 1'b0; last = 1'b0;
    tick();

    // asynchronous reset mid-ACCUM after 3 beats
    in_valid = 1'b1; acc_mode = 1'b1; op = 3'b000; a = 8'hFF; b = 8'hFF;
    tick(); tick(); tick();
    chk("mid_cnt", count, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_vld", out_valid, 0);
    chk("async_rst_y", y, 8'h00);
    chk("async_rst_cnt", count, 0);
    in_valid = 1'b0; acc_mode = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_rdy", in_ready, 1);
    in_valid = 1'b1; op = 3'b010; a = 8'h12; b = 8'h34;
    tick();
    chk("fresh_y", y, 8'h26);
    chk("fresh_vld", out_valid, 1);
    chk("fresh_cnt", count, 1);
    in_valid = 1'b0;
    tick();

`ifdef PORTA_LOGICA_ZERO_FLAG_EN
    in_valid = 1'b1; op = 3'b010; a = 8'h5A; b = 8'h5A;
    tick();
    chk("zf_y", y, 8'h00);
    chk("zf_set", zf, 1);
    op = 3'b001; a = 8'h00; b = 8'h01;
    tick();
    chk("zf_clr", zf, 0);
    in_valid = 1'b0;
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
